// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the register slave:
// transfer/size encodings, response codes and slave FSM states.
package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'd0,
      HT_BUSY   = 2'd1,
      HT_NONSEQ = 2'd2,
      HT_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HS_BYTE = 3'd0,
      HS_HALF = 3'd1,
      HS_WORD = 3'd2
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

endpackage

// File: rtl/ahb_reg_slave_if.sv
// AHB-Lite bus bundle between master/decoder side
// and the register slave.
interface ahb_reg_slave_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              hsel_x;
   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic              hready;
   logic [DATA_W-1:0] hwdata;
   logic [DATA_W-1:0] hrdata;
   logic              hready_out;
   logic              hresp;

   modport master (
      output hsel_x, haddr, htrans, hwrite,
      output hsize, hready, hwdata,
      input  hrdata, hready_out, hresp
   );

   modport slave (
      input  hsel_x, haddr, htrans, hwrite,
      input  hsize, hready, hwdata,
      output hrdata, hready_out, hresp
   );
endinterface

// File: rtl/ahb_lane_mask.sv
// Byte-enable mask from transfer size and low
// address bits; full-width sizes enable every lane.
module ahb_lane_mask #(
   parameter int DATA_W = 32,
   parameter int AW     = 2
) (
   input  logic [2:0]          hsize,
   input  logic [AW-1:0]       addr,
   output logic [DATA_W/8-1:0] mask
);
   localparam int NB     = DATA_W / 8;
   localparam int LOG_NB = $clog2(NB);

   logic [AW-1:0] lane;

   // A lane belongs to the transfer when it shares
   // the size-aligned block with the address.
   always_comb begin
      mask = '0;
      lane = '0;
      for (int b = 0; b < NB; b++) begin
         lane = AW'(b);
         if (int'(hsize) >= LOG_NB)
            mask[b] = 1'b1;
         else
            mask[b] = (lane >> hsize) == (addr >> hsize);
      end
   end
endmodule

// File: rtl/ahb_reg_slave.sv
// AHB-Lite register bank slave with pipelined
// address/data phases, wait states and ERROR response.
module ahb_reg_slave
   import ahb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 8,
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic                       hclk,
   input  logic                       hreset_n,
   ahb_reg_slave_if.slave             bus,
   output logic [NUM_REGS*DATA_W-1:0] regs_o
);
   localparam int NB     = DATA_W / 8;
   localparam int LOG_NB = $clog2(NB);
   localparam int AW     = (LOG_NB > 0) ? LOG_NB : 1;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

   state_t            state_q, state_d, acc_st;
   htrans_t           trans;
   logic [ADDR_W-1:0] addr_q, amask;
   logic              write_q;
   logic [2:0]        size_q;
   logic [2:0]        wcnt_q;
   logic              accept, acc_err, cap;
   logic [NB-1:0]     lane_m;
   logic [DATA_W-1:0] bit_m;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   assign trans  = htrans_t'(bus.htrans);
   assign accept = bus.hsel_x & bus.hready &
                   ((trans == HT_NONSEQ) | (trans == HT_SEQ));

   always_comb begin
      amask   = ADDR_W'((32'd1 << bus.hsize) - 32'd1);
      acc_err = ((bus.haddr >> LOG_NB) >= ADDR_W'(NUM_REGS)) |
                (int'(bus.hsize) > LOG_NB) |
                (|(bus.haddr & amask));
      acc_st  = ST_IDLE;
      if (accept)
         acc_st = acc_err ? ST_ERR1 :
                  (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
   end

   always_comb begin
      state_d        = state_q;
      cap            = 1'b0;
      bus.hready_out = 1'b1;
      bus.hresp      = HRESP_OKAY;
      unique case (state_q)
         ST_IDLE: begin
            state_d = acc_st;
            cap     = accept;
         end
         ST_WAIT: begin
            bus.hready_out = 1'b0;
            if (wcnt_q == WS_LAST)
               state_d = ST_DATA;
         end
         ST_DATA: begin
            state_d = acc_st;
            cap     = accept;
         end
         ST_ERR1: begin
            bus.hready_out = 1'b0;
            bus.hresp      = HRESP_ERROR;
            state_d        = ST_ERR2;
         end
         ST_ERR2: begin
            bus.hresp = HRESP_ERROR;
            state_d   = acc_st;
            cap       = accept;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= (state_q == ST_WAIT) ? wcnt_q + 3'd1 : 3'd0;
         if (cap) begin
            addr_q  <= bus.haddr;
            write_q <= bus.hwrite;
            size_q  <= bus.hsize;
         end
      end
   end

   ahb_lane_mask #(
      .DATA_W(DATA_W),
      .AW    (AW)
   ) u_lane_mask (
      .hsize(size_q),
      .addr (AW'(addr_q)),
      .mask (lane_m)
   );

   always_comb begin
      bit_m = '0;
      for (int b = 0; b < NB; b++)
         bit_m[b*8 +: 8] = {8{lane_m[b]}};
   end

   assign idx = IDX_W'(addr_q >> LOG_NB);

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
      end else if (state_q == ST_DATA && write_q) begin
         regs_q[idx] <= (regs_q[idx] & ~bit_m) |
                        (bus.hwdata & bit_m);
      end
   end

   assign bus.hrdata = (state_q == ST_DATA && !write_q) ?
                       (regs_q[idx] & bit_m) : '0;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
   end
endmodule

// File: tb/tb_ahb_reg_slave.sv
// Bench for ahb_reg_slave: pipelined vector table,
// error responses, wait states and async reset.
module tb_ahb_reg_slave;
   import ahb_pkg::*;

   localparam int DW  = 32;
   localparam int NR  = 8;
   localparam int AWD = 8;
   localparam int NV  = 16;

   logic hclk = 1'b0;
   logic hreset_n = 1'b0;
   always #5 hclk = ~hclk;

   ahb_reg_slave_if #(.ADDR_W(AWD), .DATA_W(DW)) b0 ();
   ahb_reg_slave_if #(.ADDR_W(AWD), .DATA_W(DW)) b1 ();
   assign b0.hready = b0.hready_out;
   assign b1.hready = b1.hready_out;

   logic [NR*DW-1:0] regs0, regs1;

   ahb_reg_slave #(
      .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AWD), .WAIT_STATES(0)
   ) u0 (
      .hclk(hclk), .hreset_n(hreset_n), .bus(b0.slave), .regs_o(regs0)
   );

   ahb_reg_slave #(
      .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AWD), .WAIT_STATES(2)
   ) u1 (
      .hclk(hclk), .hreset_n(hreset_n), .bus(b1.slave), .regs_o(regs1)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  tr;
      logic        wr;
      logic [2:0]  sz;
      logic [7:0]  ad;
      logic [31:0] wd;
      logic [31:0] rd;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      int          id;
   } exp_t;

   vec_t vt [NV];
   exp_t sbq [$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mkv(logic sel, logic [1:0] tr, logic wr,
                                logic [2:0] sz, logic [7:0] ad,
                                logic [31:0] wd, logic [31:0] rd);
      vec_t v;
      v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz;
      v.ad = ad; v.wd = wd; v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic idle0();
      b0.hsel_x = 1'b0; b0.htrans = HT_IDLE; b0.hwrite = 1'b0;
      b0.hsize = 3'd2; b0.haddr = '0;
   endtask

   task automatic idle1();
      b1.hsel_x = 1'b0; b1.htrans = HT_IDLE; b1.hwrite = 1'b0;
      b1.hsize = 3'd2; b1.haddr = '0;
   endtask

   task automatic req1(input logic wr, input logic [7:0] ad);
      b1.hsel_x = 1'b1; b1.htrans = HT_NONSEQ; b1.hwrite = wr;
      b1.hsize = 3'd2; b1.haddr = ad;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NR*DW-1:0] snap;
      exp_t e;
      int   k;
      bit   got;
      logic       ew [4];
      logic [2:0] es [4];
      logic [7:0] ea [4];

      vt[0]  = mkv(1'b1, HT_NONSEQ, 1'b1, 3'd2, 8'h04, 32'hDEADBEEF, 32'h0);
      vt[1]  = mkv(1'b1, HT_NONSEQ, 1'b0, 3'd2, 8'h04, 32'h0, 32'hDEADBEEF);
      vt[2]  = mkv(1'b1, HT_NONSEQ, 1'b1, 3'd0, 8'h05, 32'h0000AA00, 32'h0);
      vt[3]  = mkv(1'b1, HT_NONSEQ, 1'b0, 3'd2, 8'h04, 32'h0, 32'hDEADAAEF);
      vt[4]  = mkv(1'b1, HT_NONSEQ, 1'b1, 3'd2, 8'h08, 32'h00000011, 32'h0);
      vt[5]  = mkv(1'b1, HT_NONSEQ, 1'b0, 3'd2, 8'h08, 32'h0, 32'h00000011);
      vt[6]  = mkv(1'b1, HT_NONSEQ, 1'b1, 3'd1, 8'h0E, 32'hBEEF0000, 32'h0);
      vt[7]  = mkv(1'b0, HT_NONSEQ, 1'b0, 3'd2, 8'h0C, 32'h0, 32'h0);
      vt[8]  = mkv(1'b1, HT_IDLE,   1'b0, 3'd2, 8'h0C, 32'h0, 32'h0);
      vt[9]  = mkv(1'b1, HT_BUSY,   1'b0, 3'd2, 8'h0C, 32'h0, 32'h0);
      vt[10] = mkv(1'b1, HT_SEQ,    1'b0, 3'd2, 8'h0C, 32'h0, 32'hBEEF0000);
      vt[11] = mkv(1'b1, HT_NONSEQ, 1'b1, 3'd0, 8'h1F, 32'hFF000000, 32'h0);
      vt[12] = mkv(1'b1, HT_NONSEQ, 1'b0, 3'd2, 8'h1C, 32'h0, 32'hFF000000);
      vt[13] = mkv(1'b1, HT_NONSEQ, 1'b1, 3'd2, 8'h1C, 32'h12345678, 32'h0);
      vt[14] = mkv(1'b1, HT_NONSEQ, 1'b1, 3'd1, 8'h1C, 32'h0000ABCD, 32'h0);
      vt[15] = mkv(1'b1, HT_NONSEQ, 1'b0, 3'd2, 8'h1C, 32'h0, 32'h1234ABCD);

      ew[0] = 1'b0; es[0] = 3'd2; ea[0] = 8'h20;
      ew[1] = 1'b1; es[1] = 3'd2; ea[1] = 8'h02;
      ew[2] = 1'b1; es[2] = 3'd3; ea[2] = 8'h00;
      ew[3] = 1'b1; es[3] = 3'd1; ea[3] = 8'h05;

      idle0(); idle1();
      b0.hwdata = '0; b1.hwdata = '0;
      #1;
      chk("rst_ready", 32'(b0.hready_out), 32'd1);
      chk("rst_resp", 32'(b0.hresp), 32'd0);
      chk("rst_rdata", b0.hrdata, 32'h0);
      chk("rst_regs_nz", 32'(|regs0), 32'd0);
      repeat (2) @(posedge hclk);
      #1 hreset_n = 1'b1;

      for (int t = 0; t <= NV; t++) begin
         @(posedge hclk); #1;
         if (t > 0 && vt[t-1].wr) b0.hwdata = vt[t-1].wd;
         else b0.hwdata = '0;
         if (t < NV) begin
            b0.hsel_x = vt[t].sel; b0.htrans = vt[t].tr;
            b0.hwrite = vt[t].wr;  b0.hsize = vt[t].sz;
            b0.haddr = vt[t].ad;
            sbq.push_back('{vt[t].rd, t});
         end else begin
            idle0();
         end
         @(negedge hclk);
         if (t > 0) begin
            e = sbq.pop_front();
            chk($sformatf("vec%0d_rdata", e.id), b0.hrdata, e.rd);
            chk($sformatf("vec%0d_ready", e.id), 32'(b0.hready_out), 32'd1);
            chk($sformatf("vec%0d_resp", e.id), 32'(b0.hresp), 32'd0);
         end
      end
      chk("reg2", regs0[2*DW +: DW], 32'h00000011);
      chk("reg3", regs0[3*DW +: DW], 32'hBEEF0000);
      chk("reg7", regs0[7*DW +: DW], 32'h1234ABCD);

      for (int n = 0; n < 4; n++) begin
         snap = regs0;
         @(posedge hclk); #1;
         b0.hsel_x = 1'b1; b0.htrans = HT_NONSEQ; b0.hwrite = ew[n];
         b0.hsize = es[n]; b0.haddr = ea[n]; b0.hwdata = '0;
         @(posedge hclk); #1;
         idle0(); b0.hwdata = 32'hFFFFFFFF;
         @(negedge hclk);
         chk($sformatf("err%0d_e1_ready", n), 32'(b0.hready_out), 32'd0);
         chk($sformatf("err%0d_e1_resp", n), 32'(b0.hresp), 32'd1);
         @(negedge hclk);
         chk($sformatf("err%0d_e2_ready", n), 32'(b0.hready_out), 32'd1);
         chk($sformatf("err%0d_e2_resp", n), 32'(b0.hresp), 32'd1);
         @(negedge hclk);
         chk($sformatf("err%0d_idle_resp", n), 32'(b0.hresp), 32'd0);
         checks++;
         if (regs0 !== snap) begin
            errors++;
            $display("FAIL err%0d_regs got=%h want=%h", n, regs0, snap);
         end
      end

      @(posedge hclk); #1;
      req1(1'b1, 8'h04);
      @(negedge hclk);
      chk("ws_addr_ready", 32'(b1.hready_out), 32'd1);
      @(posedge hclk); #1;
      idle1(); b1.hwdata = 32'hCAFEF00D;
      @(negedge hclk);
      chk("ws_c1_ready", 32'(b1.hready_out), 32'd0);
      chk("ws_c1_resp", 32'(b1.hresp), 32'd0);
      @(negedge hclk);
      chk("ws_c2_ready", 32'(b1.hready_out), 32'd0);
      @(negedge hclk);
      chk("ws_c3_ready", 32'(b1.hready_out), 32'd1);
      chk("ws_c3_reg1", regs1[DW +: DW], 32'h0);
      @(negedge hclk);
      chk("ws_commit_reg1", regs1[DW +: DW], 32'hCAFEF00D);

      @(posedge hclk); #1;
      req1(1'b0, 8'h04); b1.hwdata = '0;
      sbq.push_back('{32'hCAFEF00D, 100});
      @(posedge hclk); #1;
      idle1();
      got = 1'b0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge hclk);
         if (b1.hready_out) begin
            got = 1'b1;
            break;
         end
         k++;
      end
      chk("ws_rd_done", 32'(got), 32'd1);
      chk("ws_rd_waits", 32'(k), 32'd2);
      e = sbq.pop_front();
      chk($sformatf("ws_rd%0d_rdata", e.id), b1.hrdata, e.rd);

      @(posedge hclk); #1;
      req1(1'b1, 8'h08);
      @(posedge hclk); #1;
      idle1(); b1.hwdata = 32'h55AA55AA;
      chk("rw_pre_ready", 32'(b1.hready_out), 32'd0);
      #2 hreset_n = 1'b0;
      #1;
      chk("rw_ready", 32'(b1.hready_out), 32'd1);
      chk("rw_resp", 32'(b1.hresp), 32'd0);
      chk("rw_regs1_nz", 32'(|regs1), 32'd0);
      chk("rw_regs0_nz", 32'(|regs0), 32'd0);
      @(posedge hclk); #1;
      hreset_n = 1'b1;
      repeat (4) @(negedge hclk);
      chk("rw_post_reg2", regs1[2*DW +: DW], 32'h0);
      chk("rw_post_ready", 32'(b1.hready_out), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
